// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one carry-lookahead adder/subtractor between
// N_REQ requesters. One job in flight: grant (IDLE) -> compute (CALC) ->
// hold result until the owner accepts it (DONE).
module addsub_rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0][7:0] req_a,
  input  logic [N_REQ-1:0][7:0] req_b,
  input  logic [N_REQ-1:0]      req_sub,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [8:0]            rsp_sum,
  output logic                  busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [7:0]       op_a_q, op_a_d;
  logic [7:0]       op_b_q, op_b_d;
  logic             op_sub_q, op_sub_d;
  logic [8:0]       sum_q, sum_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] ptr_inc;

  logic [7:0]       b_eff;
  logic [7:0]       gen;
  logic [7:0]       prop;
  logic [4:0]       c_lo;
  logic [4:0]       c_hi;
  logic [8:0]       add_sum;

  // 4-bit lookahead carries; c[0] is the carry in, c[4] the carry out.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & ci);
    return c;
  endfunction

  // Winner search: first valid requester starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Pointer moves to the slot after the winner so it has lowest priority next time.
  always_comb begin
    ptr_inc = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
  end

  // Shared adder/subtractor, fed only from the operand registers.
  always_comb begin
    b_eff   = op_b_q ^ {8{op_sub_q}};
    gen     = op_a_q & b_eff;
    prop    = op_a_q ^ b_eff;
    c_lo    = cla4(gen[3:0], prop[3:0], op_sub_q);
    c_hi    = cla4(gen[7:4], prop[7:4], c_lo[4]);
    // Bit 8 is the sign-extended sum, so the 9-bit result never overflows.
    add_sum = {op_a_q[7] ^ b_eff[7] ^ c_hi[4],
               prop ^ {c_hi[3:0], c_lo[3:0]}};
  end

  // Next-state logic for the job FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sub_d = op_sub_q;
    sum_d    = sum_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = CALC;
          owner_d  = winner;
          ptr_d    = ptr_inc;
          op_a_d   = req_a[winner];
          op_b_d   = req_b[winner];
          op_sub_d = req_sub[winner];
        end
      end
      CALC: begin
        sum_d   = add_sum;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous reset wins over any transfer or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sub_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sub_q <= op_sub_d;
      sum_q    <= sum_d;
    end
  end

  // Handshake outputs are masked during reset so nothing transfers into a discarded cycle.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (!rst && state_q == IDLE && found) begin
      req_ready = N_REQ'(1) << winner;
    end
    if (!rst && state_q == DONE) begin
      rsp_valid = N_REQ'(1) << owner_q;
    end
    rsp_sum = sum_q;
    busy    = (state_q != IDLE);
  end

endmodule
